adc_captura: RTL
================

# adc_captura

Upstream acquisition stage for the 20 kHz low-pass filter chain. Generates the sample-rate tick, drives a 12-bit serial ADC (AD7476-style, 16-clock frame), converts each unsigned code to a signed 25-bit fixed-point sample, and presents it with a one-cycle `Enable` strobe. `u` and `Enable` connect directly to the filter's `u` and `Enable` inputs.

## Interface
- `W`, 25: output sample width; must match the filter.
- `FRAC`, 15: fractional bits of the output format; full scale is ±1.0. Requires `FRAC >= 11`.
- `DIV`, 1000: CLK cycles per sample period (100 kSps at 100 MHz). Requires `DIV >= 33*SCLK_HALF + 3`.
- `SCLK_HALF`, 4: CLK cycles per SCLK half-period (12.5 MHz at 100 MHz). Must be at least 2.

Ports:
- `CLK` in, 1: system clock; all logic on the rising edge.
- `Reset` in, 1: asynchronous, active-high.
- `Run` in, 1: enables sampling; level-sensitive.
- `SDATA` in, 1: ADC serial data, pre-synchronised externally.
- `CS_n` out, 1: ADC chip select, active-low.
- `SCLK` out, 1: ADC serial clock; idles high.
- `u` out, W: signed sample, held between strobes.
- `Enable` out, 1: one-cycle strobe marking a new `u`.
- `Busy` out, 1: high while a frame is in progress.
- `Overrun` out, 1: sticky flag; cleared only by `Reset`.

## Operation
- **Tick counter:** counts 0..DIV-1 and wraps. A tick occurs on the wrap cycle. The counter runs regardless of `Run`.
- **States:**
  - `IDLE`: waits for a tick with `Run=1`, then goes to `SETUP`.
  - `SETUP`: `CS_n=0`, `SCLK=1` for SCLK_HALF cycles, then goes to `SHIFT`.
  - `SHIFT`: 16 SCLK periods, each low for SCLK_HALF cycles then high for SCLK_HALF cycles. `SDATA` is sampled on the CLK edge where `SCLK` goes low→high and shifted in MSB first.
  - `DONE`: one cycle, then back to `IDLE`.
- **Frame decode:** bits 15..12 are leading zeros and are ignored. Bits 11..0 form code `c`.
- **Conversion:** x = c − 2048, computed as a 13-bit signed value. Then u = sign_extend_W(x) << (FRAC−11).
  - Examples: c=0 gives −1.0; c=2048 gives 0; c=4095 gives +4095/4096·... (that is, +2047/2048).
- **`DONE` cycle:** `CS_n=1`, `SCLK=1`, `u` is loaded, `Enable=1`. `Busy` is high in `SETUP` and `SHIFT`, low in `IDLE` and `DONE`.
- **`Run` deasserted mid-frame:** the current frame completes and is delivered; no new frame starts.
- **Tick while not in `IDLE` (any `Run`):** the tick is ignored and `Overrun` is set. With a legal `DIV` this cannot occur.
- **Reset mid-frame:** the frame is aborted immediately and no strobe is issued.

## Timing
- **Reset values:** `CS_n=1`, `SCLK=1`, `u=0`, `Enable=0`, `Busy=0`, `Overrun=0`, tick counter 0, state `IDLE`.
- **Frame timing from a tick in cycle T:**
  - `CS_n` falls at T+1.
  - First `SCLK` fall at T+1+SCLK_HALF.
  - 16th `SCLK` rise at T+1+32·SCLK_HALF.
  - `DONE` (`Enable`, new `u`) at T+1+33·SCLK_HALF, which is T+133 with defaults.
- **Outputs:** `u` changes only in the `Enable` cycle. Exactly one strobe per frame. Strobe spacing equals `DIV` under continuous `Run`.
- **Register inputs:** `Run` is sampled only in `IDLE` on the tick cycle. A tick coinciding with `Run` rising starts a frame.

## Structure
- **Shared package (`filtro_pkg`):** `W`, `FRAC`, ADC constants `ADC_BITS=12`, `FRAME_BITS=16`, `ADC_MID=2048`, and the state enumeration (`IDLE`, `SETUP`, `SHIFT`, `DONE`).
- **Sub-module `tick_divider`:** parameterised modulo counter producing the one-cycle tick. Reused for SCLK half-period timing inside `SHIFT`.

## Test plan
- **Reset mid-`SHIFT`:** assert `Reset` during frame bit 7 → next cycle all outputs return to reset values; no `Enable` for that frame.
- **Single conversion:** ADC model returns frame 0x0FFF, `Run=1`, defaults → `Enable` 133 cycles after the tick, `u`=0x007FF0, `CS_n` low exactly 132 cycles, exactly 16 `SCLK` rises.
- **Code sweep:** codes 0x000, 0x800, 0x001 → `u` = 0x1FF8000, 0x0000000, 0x1FF8010 respectively.
- **Continuous run:** `Run=1` for 5 periods → strobes exactly 1000 cycles apart, `Overrun` stays 0.
- **`Run` drop mid-frame:** deassert `Run` during `SHIFT` → that frame's strobe still occurs; no further `CS_n` fall.
- **Overrun:** `DIV=100`, `SCLK_HALF=4` (illegal) → `Overrun`=1 after the first frame, and it stays set until `Reset`.

Source files
------------

// File: rtl/filtro_pkg.sv
// Constants and state encoding shared by the ADC acquisition front end and the filter chain.
package filtro_pkg;

  localparam int W          = 25;
  localparam int FRAC       = 15;
  localparam int ADC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int ADC_MID    = 2048;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  // Offset-binary ADC code to a signed offset around mid-scale.
  function automatic logic signed [ADC_BITS:0] code_to_offset(input logic [ADC_BITS-1:0] code);
    logic [ADC_BITS:0] diff;
    diff = {1'b0, code} - (ADC_BITS + 1)'(ADC_MID);
    return signed'(diff);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo-N counter producing a one-cycle tick on its wrap cycle, with synchronous clear.
module tick_divider #(
  parameter int N = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/adc_captura.sv
// Sample-rate tick, serial ADC frame capture and conversion to a signed fixed-point sample
// with a one-cycle strobe for the downstream filter.
module adc_captura #(
  parameter int W         = filtro_pkg::W,
  parameter int FRAC      = filtro_pkg::FRAC,
  parameter int DIV       = 1000,
  parameter int SCLK_HALF = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Run,
  input  logic         SDATA,
  output logic         CS_n,
  output logic         SCLK,
  output logic [W-1:0] u,
  output logic         Enable,
  output logic         Busy,
  output logic         Overrun
);

  import filtro_pkg::*;

  localparam int             BCW      = $clog2(FRAME_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS);
  localparam int             SHIFT_UP = FRAC - (ADC_BITS - 1);

  state_t              state_q;
  logic                cs_n_q;
  logic                sclk_q;
  logic                enable_q;
  logic                busy_q;
  logic                overrun_q;
  logic [W-1:0]        u_q;
  logic [ADC_BITS-1:0] shift_q;
  logic [BCW-1:0]      bit_cnt_q;

  logic                       sample_tick;
  logic                       phase_tick;
  logic                       phase_run;
  logic signed [ADC_BITS:0]   offset;
  logic [W-1:0]               sample_d;

  tick_divider #(.N(DIV)) u_rate (
    .clk_i (CLK),
    .rst_i (Reset),
    .clr_i (1'b0),
    .en_i  (1'b1),
    .tick_o(sample_tick)
  );

  // Half-period timer restarts from zero each frame so SETUP and every SCLK phase last SCLK_HALF.
  assign phase_run = (state_q == SETUP) || (state_q == SHIFT);

  tick_divider #(.N(SCLK_HALF)) u_phase (
    .clk_i (CLK),
    .rst_i (Reset),
    .clr_i (!phase_run),
    .en_i  (phase_run),
    .tick_o(phase_tick)
  );

  // The shift register keeps only the last 12 bits, so the leading zeros fall off the top.
  assign offset   = code_to_offset(shift_q);
  assign sample_d = {{(W - ADC_BITS - 1){offset[ADC_BITS]}}, offset} << SHIFT_UP;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      u_q       <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      enable_q <= 1'b0;
      if (sample_tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sample_tick && Run) begin
            state_q   <= SETUP;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        SETUP: begin
          if (phase_tick) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (phase_tick) begin
            if (!sclk_q) begin
              sclk_q    <= 1'b1;
              shift_q   <= {shift_q[ADC_BITS-2:0], SDATA};
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end else if (bit_cnt_q == LAST_BIT) begin
              // End of the 16th high phase: SCLK stays high into DONE.
              state_q  <= DONE;
              cs_n_q   <= 1'b1;
              busy_q   <= 1'b0;
              u_q      <= sample_d;
              enable_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign CS_n    = cs_n_q;
  assign SCLK    = sclk_q;
  assign u       = u_q;
  assign Enable  = enable_q;
  assign Busy    = busy_q;
  assign Overrun = overrun_q;

endmodule
